// File: rtl/abro_pkg.sv
// Shared types and limits for the N-input ABRO join synchroniser.
package abro_pkg;

  localparam int ABRO_MAX_N = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } abro_state_t;

endpackage

// File: rtl/abro_timer.sv
// Collection-window counter: clear beats enable; expires when the count reaches TIMEOUT.
// With TIMEOUT=0 it degenerates to a constant that never expires.
module abro_timer #(
  parameter int unsigned TIMEOUT = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  if (TIMEOUT == 0) begin : g_off
    logic unused_tie;
    assign unused_tie = ^{clk, reset_n, clr, en};
    assign expired    = 1'b0;
  end else begin : g_on
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (clr)     cnt_d = '0;
      else if (en) cnt_d = cnt_q + TW'(1);
    end

    always_ff @(posedge clk) begin
      if (!reset_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
    end

    // Expiry always coincides with a clear, so the counter never wraps.
    assign expired = (cnt_q == TW'(TIMEOUT));
  end

endmodule

// File: rtl/abro_n_sync.sv
// N-input ABRO join: fires o once every req channel has been seen high, holds until r.
// Optional collection timeout abandons a partial round.
module abro_n_sync
  import abro_pkg::*;
#(
  parameter int          N          = 2,
  parameter int          PULSE_MODE = 1,
  parameter int unsigned TIMEOUT    = 0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         r,
  input  logic [N-1:0] req,
  output logic         o,
  output logic         timeout,
  output logic [N-1:0] seen,
  output logic [1:0]   state
);

  abro_state_t  state_q, state_d;
  logic [N-1:0] seen_q, seen_d, hit;
  logic         o_q, o_d, to_q, to_d;
  logic         t_clr, t_en, t_exp;

  assign hit = seen_q | req;

  abro_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clr     (t_clr),
    .en      (t_en),
    .expired (t_exp)
  );

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    o_d     = 1'b0;
    to_d    = 1'b0;
    t_clr   = 1'b0;
    t_en    = 1'b0;
    if (r) begin
      state_d = IDLE;
      seen_d  = '0;
      t_clr   = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          // Timer is zero in IDLE, so enabling it lands on 1 at entry to COLLECT.
          if (&hit) begin
            state_d = DONE;
            seen_d  = '1;
          end else if (|hit) begin
            state_d = COLLECT;
            seen_d  = hit;
            t_en    = 1'b1;
          end
        end
        COLLECT: begin
          if (&hit) begin
            state_d = DONE;
            seen_d  = '1;
            t_clr   = 1'b1;
          end else if (t_exp) begin
            state_d = IDLE;
            seen_d  = '0;
            to_d    = 1'b1;
            t_clr   = 1'b1;
          end else begin
            seen_d  = hit;
            t_en    = 1'b1;
          end
        end
        DONE:    seen_d = '1;
        default: begin
          state_d = IDLE;
          seen_d  = '0;
          t_clr   = 1'b1;
        end
      endcase
    end
    if (state_d == DONE) o_d = (PULSE_MODE == 0) || (state_q != DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      seen_q  <= '0;
      o_q     <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      seen_q  <= seen_d;
      o_q     <= o_d;
      to_q    <= to_d;
    end
  end

  assign o       = o_q;
  assign timeout = to_q;
  assign seen    = seen_q;
  assign state   = state_q;

endmodule

// File: tb/tb_abro_n_sync.sv
// Bench for abro_n_sync: four configurations share one stimulus stream and are
// checked against a round-based reference model, plus directed tables/sequences.
module tb_abro_n_sync;

  localparam int          ND         = 4;
  localparam int          NN [ND]    = '{2, 4, 3, 8};
  localparam int          PM [ND]    = '{1, 0, 1, 1};
  localparam int unsigned TO [ND]    = '{0, 0, 5, 0};

  localparam int P_IDLE = 0, P_COLLECT = 1, P_DONE = 2;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       r = 1'b0;
  logic [7:0] req_b = '0;

  logic [1:0] st_w [ND];
  logic [7:0] sn_w [ND];
  logic       o_w  [ND];
  logic       to_w [ND];

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    logic [NN[g]-1:0] sn;
    logic [1:0]       st;
    logic             o_l, to_l;
    abro_n_sync #(.N(NN[g]), .PULSE_MODE(PM[g]), .TIMEOUT(TO[g])) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .r       (r),
      .req     (req_b[NN[g]-1:0]),
      .o       (o_l),
      .timeout (to_l),
      .seen    (sn),
      .state   (st)
    );
    assign sn_w[g] = 8'(sn);
    assign st_w[g] = st;
    assign o_w[g]  = o_l;
    assign to_w[g] = to_l;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int       m_phase [ND];
  bit [7:0] m_seen  [ND];
  bit       m_o     [ND];
  bit       m_to    [ND];
  int       m_start [ND];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", nm, cyc, act, exp);
    end
  endtask

  // Round model: a round starts at the first partial hit, and its age is edges since start.
  function automatic void model_step(int i, bit rn, bit rr, bit [7:0] rq);
    bit [7:0] full = 8'hFF >> (8 - NN[i]);
    bit [7:0] h    = (m_seen[i] | rq) & full;
    m_to[i] = 1'b0;
    m_o[i]  = 1'b0;
    if (!rn || rr) begin
      m_phase[i] = P_IDLE;
      m_seen[i]  = '0;
      return;
    end
    if (m_phase[i] == P_DONE) begin
      m_o[i] = (PM[i] == 0);
      return;
    end
    if (h == full) begin
      m_phase[i] = P_DONE;
      m_seen[i]  = full;
      m_o[i]     = 1'b1;
      return;
    end
    if (m_phase[i] == P_COLLECT && TO[i] != 0 && (cyc - m_start[i]) == int'(TO[i])) begin
      m_phase[i] = P_IDLE;
      m_seen[i]  = '0;
      m_to[i]    = 1'b1;
      return;
    end
    if (h != 0 && m_phase[i] == P_IDLE) begin
      m_phase[i] = P_COLLECT;
      m_start[i] = cyc;
    end
    m_seen[i] = h;
  endfunction

  task automatic step(input bit rn, input bit rr, input bit [7:0] rq);
    reset_n = rn;
    r       = rr;
    req_b   = rq;
    @(posedge clk);
    cyc++;
    for (int i = 0; i < ND; i++) model_step(i, rn, rr, rq);
    #1;
    for (int i = 0; i < ND; i++) begin
      chk($sformatf("d%0d_state", i), 32'(st_w[i]), 32'(m_phase[i]));
      chk($sformatf("d%0d_seen", i),  32'(sn_w[i]), 32'(m_seen[i]));
      chk($sformatf("d%0d_o", i),     32'(o_w[i]),  32'(m_o[i]));
      chk($sformatf("d%0d_timeout", i), 32'(to_w[i]), 32'(m_to[i]));
    end
  endtask

  typedef struct {
    bit       rn;
    bit       r;
    bit [7:0] req;
    bit [1:0] st;
    bit       o;
    bit [1:0] sn;
  } vec_t;

  vec_t tbl [19];

  initial begin
    // Directed vectors for the N=2 pulse-mode instance (expected after each edge).
    tbl[0]  = '{1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 2'b00};
    tbl[1]  = '{1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 2'b00};
    tbl[2]  = '{1'b1, 1'b0, 8'h01, 2'd1, 1'b0, 2'b01};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 2'd1, 1'b0, 2'b01};
    tbl[4]  = '{1'b1, 1'b0, 8'h00, 2'd1, 1'b0, 2'b01};
    tbl[5]  = '{1'b1, 1'b0, 8'h00, 2'd1, 1'b0, 2'b01};
    tbl[6]  = '{1'b1, 1'b0, 8'h02, 2'd2, 1'b1, 2'b11};
    tbl[7]  = '{1'b1, 1'b0, 8'h00, 2'd2, 1'b0, 2'b11};
    tbl[8]  = '{1'b1, 1'b0, 8'h03, 2'd2, 1'b0, 2'b11};
    tbl[9]  = '{1'b1, 1'b1, 8'h03, 2'd0, 1'b0, 2'b00};
    tbl[10] = '{1'b1, 1'b1, 8'h03, 2'd0, 1'b0, 2'b00};
    tbl[11] = '{1'b1, 1'b0, 8'h03, 2'd2, 1'b1, 2'b11};
    tbl[12] = '{1'b1, 1'b0, 8'h03, 2'd2, 1'b0, 2'b11};
    tbl[13] = '{1'b1, 1'b1, 8'h00, 2'd0, 1'b0, 2'b00};
    tbl[14] = '{1'b1, 1'b0, 8'h01, 2'd1, 1'b0, 2'b01};
    tbl[15] = '{1'b1, 1'b1, 8'h02, 2'd0, 1'b0, 2'b00};
    tbl[16] = '{1'b1, 1'b0, 8'h01, 2'd1, 1'b0, 2'b01};
    tbl[17] = '{1'b0, 1'b0, 8'h02, 2'd0, 1'b0, 2'b00};
    tbl[18] = '{1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 2'b00};

    for (int i = 0; i < ND; i++) begin
      m_phase[i] = P_IDLE; m_seen[i] = '0; m_o[i] = 1'b0; m_to[i] = 1'b0; m_start[i] = 0;
    end

    for (int k = 0; k < 19; k++) begin
      step(tbl[k].rn, tbl[k].r, tbl[k].req);
      chk($sformatf("tbl%0d_state", k), 32'(st_w[0]), 32'(tbl[k].st));
      chk($sformatf("tbl%0d_o", k),     32'(o_w[0]),  32'(tbl[k].o));
      chk($sformatf("tbl%0d_seen", k),  32'(sn_w[0]), 32'(tbl[k].sn));
    end

    // N=3, TIMEOUT=5: lone partial hit times out five edges later.
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h01);
    chk("to_enter_state", 32'(st_w[2]), 32'd1);
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 1'b0, 8'h00);
      chk("to_wait_timeout", 32'(to_w[2]), 32'd0);
    end
    step(1'b1, 1'b0, 8'h00);
    chk("to_pulse", 32'(to_w[2]), 32'd1);
    chk("to_state", 32'(st_w[2]), 32'd0);
    chk("to_seen",  32'(sn_w[2]), 32'd0);
    chk("to_o",     32'(o_w[2]),  32'd0);
    step(1'b1, 1'b0, 8'h00);
    chk("to_pulse_end", 32'(to_w[2]), 32'd0);

    // Completion on the expiry edge wins over timeout.
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h01);
    step(1'b1, 1'b0, 8'h02);
    for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h04);
    chk("exp_win_state",   32'(st_w[2]), 32'd2);
    chk("exp_win_o",       32'(o_w[2]),  32'd1);
    chk("exp_win_timeout", 32'(to_w[2]), 32'd0);

    // N=4 level mode: all at once goes straight to DONE, o held until r.
    step(1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h0F);
    chk("lvl_state", 32'(st_w[1]), 32'd2);
    chk("lvl_o0",    32'(o_w[1]),  32'd1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 8'h00);
      chk("lvl_o_hold", 32'(o_w[1]), 32'd1);
    end
    step(1'b1, 1'b1, 8'h00);
    chk("lvl_r_o",     32'(o_w[1]),  32'd0);
    chk("lvl_r_state", 32'(st_w[1]), 32'd0);
    chk("lvl_r_seen",  32'(sn_w[1]), 32'd0);

    // N=8 pulse mode: req held through DONE gives a single pulse per round.
    step(1'b1, 1'b0, 8'hFF);
    chk("n8_o_first", 32'(o_w[3]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      step(1'b1, 1'b0, 8'hFF);
      chk("n8_no_repulse", 32'(o_w[3]), 32'd0);
      chk("n8_done",       32'(st_w[3]), 32'd2);
    end
    step(1'b1, 1'b1, 8'hFF);
    chk("n8_r_state", 32'(st_w[3]), 32'd0);
    step(1'b1, 1'b0, 8'hFF);
    chk("n8_o_again", 32'(o_w[3]), 32'd1);

    // Random traffic: sparse requests so rounds span many cycles and timeouts occur.
    for (int k = 0; k < 4000; k++) begin
      bit       rn_v = ($urandom_range(63) != 0);
      bit       r_v  = ($urandom_range(15) == 0);
      bit [7:0] rq_v = 8'($urandom & $urandom & $urandom);
      step(rn_v, r_v, rq_v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
